// File: rtl/pkt_size_meter_pkg.sv
// Shared types and constants for the packet size meter.
// Record layout below matches the default flow/size widths of the top level.
package definitions_mtr;

  typedef enum logic {
    IDLE_MTR = 1'b0,
    ACC_MTR  = 1'b1
  } states_mtr;

  localparam int CNT_WIDTH      = 16;
  localparam int REC_A_WIDTH    = 10;
  localparam int REC_SIZE_WIDTH = 15;

  typedef struct packed {
    logic [REC_A_WIDTH-1:0]    flow;
    logic [REC_SIZE_WIDTH-1:0] size;
    logic                      sat;
  } mtr_rec_t;

endpackage

// File: rtl/pkt_size_meter_sat_cnt.sv
// Saturating up-counter with asynchronous active-low clear.
module sat_cnt #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_cnt <= '0;
    end else if (inc_i && (r_cnt != {WIDTH{1'b1}})) begin
      r_cnt <= r_cnt + WIDTH'(1);
    end
  end

  assign cnt_o = r_cnt;

endmodule

// File: rtl/pkt_size_meter.sv
// Measures packet byte length sop..eop and emits one {flow, size, sat} record per packet.
// Optional drop/error statistics are built when PKT_METER_STATS_EN is defined.
module pkt_size_meter
  import definitions_mtr::*;
#(
  parameter int A_WIDTH        = REC_A_WIDTH,
  parameter int SIZE_WIDTH     = REC_SIZE_WIDTH,
  parameter int BYTES_PER_WORD = 4,
  localparam int LB_WIDTH      = $clog2(BYTES_PER_WORD) + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  rx_valid_i,
  input  logic                  rx_sop_i,
  input  logic                  rx_eop_i,
  input  logic [LB_WIDTH-1:0]   rx_last_bytes_i,
  input  logic [A_WIDTH-1:0]    rx_flow_num_i,
  output logic                  wr_valid_o,
  input  logic                  wr_ready_i,
  output logic [A_WIDTH-1:0]    flow_num_o,
  output logic [SIZE_WIDTH-1:0] pkt_size_o,
  output logic                  sat_o,
  output logic [15:0]           drop_cnt_o,
  output logic [15:0]           err_cnt_o
);

  localparam int SUM_W = SIZE_WIDTH + 1;
  localparam logic [SUM_W-1:0] BPW_SUM  = SUM_W'(BYTES_PER_WORD);
  localparam logic [SUM_W-1:0] SIZE_MAX = {1'b0, {SIZE_WIDTH{1'b1}}};

  typedef struct packed {
    logic [A_WIDTH-1:0]    flow;
    logic [SIZE_WIDTH-1:0] size;
    logic                  sat;
  } rec_t;

  states_mtr             r_state;
  states_mtr             w_state_nxt;
  logic [SIZE_WIDTH-1:0] r_acc;
  logic [SIZE_WIDTH-1:0] w_acc_nxt;
  logic                  r_acc_sat;
  logic                  w_acc_sat_nxt;
  logic [A_WIDTH-1:0]    r_flow;
  logic [A_WIDTH-1:0]    w_flow_nxt;
  logic                  w_commit;
  rec_t                  w_commit_rec;
  rec_t                  r_rec;
  logic                  r_wr_valid;
  logic                  w_load;

  // Size arithmetic is one bit wider than the result so overflow is visible.
  logic [SUM_W-1:0]      w_lb_sum;
  logic [SUM_W-1:0]      w_acc_plus_word;
  logic [SUM_W-1:0]      w_acc_plus_last;
  logic                  w_word_ovf;
  logic                  w_last_ovf;
  logic [SIZE_WIDTH-1:0] w_acc_word_clamped;
  logic [SIZE_WIDTH-1:0] w_acc_last_clamped;

  assign w_lb_sum        = (rx_last_bytes_i == '0) ? BPW_SUM : SUM_W'(rx_last_bytes_i);
  assign w_acc_plus_word = {1'b0, r_acc} + BPW_SUM;
  assign w_acc_plus_last = {1'b0, r_acc} + w_lb_sum;
  assign w_word_ovf      = (w_acc_plus_word > SIZE_MAX);
  assign w_last_ovf      = (w_acc_plus_last > SIZE_MAX);
  assign w_acc_word_clamped = w_word_ovf ? {SIZE_WIDTH{1'b1}} : w_acc_plus_word[SIZE_WIDTH-1:0];
  assign w_acc_last_clamped = w_last_ovf ? {SIZE_WIDTH{1'b1}} : w_acc_plus_last[SIZE_WIDTH-1:0];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= IDLE_MTR;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A sop is handled identically in both states; in ACC_MTR it silently
  // abandons the open packet.
  always_comb begin
    w_state_nxt   = r_state;
    w_acc_nxt     = r_acc;
    w_acc_sat_nxt = r_acc_sat;
    w_flow_nxt    = r_flow;
    w_commit      = 1'b0;
    w_commit_rec  = '0;
    if (rx_valid_i) begin
      if (rx_sop_i) begin
        if (rx_eop_i) begin
          w_commit          = 1'b1;
          w_commit_rec.flow = rx_flow_num_i;
          w_commit_rec.size = w_lb_sum[SIZE_WIDTH-1:0];
          w_commit_rec.sat  = 1'b0;
          w_state_nxt       = IDLE_MTR;
        end else begin
          w_acc_nxt     = BPW_SUM[SIZE_WIDTH-1:0];
          w_acc_sat_nxt = 1'b0;
          w_flow_nxt    = rx_flow_num_i;
          w_state_nxt   = ACC_MTR;
        end
      end else if (r_state == ACC_MTR) begin
        if (rx_eop_i) begin
          w_commit          = 1'b1;
          w_commit_rec.flow = r_flow;
          w_commit_rec.size = w_acc_last_clamped;
          w_commit_rec.sat  = r_acc_sat | w_last_ovf;
          w_state_nxt       = IDLE_MTR;
        end else begin
          w_acc_nxt     = w_acc_word_clamped;
          w_acc_sat_nxt = r_acc_sat | w_word_ovf;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_acc     <= '0;
      r_acc_sat <= 1'b0;
      r_flow    <= '0;
    end else begin
      r_acc     <= w_acc_nxt;
      r_acc_sat <= w_acc_sat_nxt;
      r_flow    <= w_flow_nxt;
    end
  end

  // Output handshake: valid/data are registered and held until a cycle with
  // valid and ready both high; a new record may replace the one leaving in
  // that same cycle. Valid never depends combinationally on ready.
  assign w_load = w_commit & (~r_wr_valid | wr_ready_i);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_wr_valid <= 1'b0;
      r_rec      <= '0;
    end else if (w_load) begin
      r_wr_valid <= 1'b1;
      r_rec      <= w_commit_rec;
    end else if (r_wr_valid && wr_ready_i) begin
      r_wr_valid <= 1'b0;
    end
  end

  assign wr_valid_o = r_wr_valid;
  assign flow_num_o = r_rec.flow;
  assign pkt_size_o = r_rec.size;
  assign sat_o      = r_rec.sat;

`ifdef PKT_METER_STATS_EN
  logic w_drop;
  logic w_err;

  assign w_drop = w_commit & ~w_load;
  assign w_err  = rx_valid_i & (rx_sop_i ? (r_state == ACC_MTR) : (r_state == IDLE_MTR));

  sat_cnt #(.WIDTH(CNT_WIDTH)) u_drop_cnt (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .inc_i   (w_drop),
    .cnt_o   (drop_cnt_o)
  );

  sat_cnt #(.WIDTH(CNT_WIDTH)) u_err_cnt (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .inc_i   (w_err),
    .cnt_o   (err_cnt_o)
  );
`else
  assign drop_cnt_o = '0;
  assign err_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_pkt_size_meter.sv
// Self-checking bench for pkt_size_meter: directed cases plus randomized traffic
// against a packet-level reference model.
module tb_pkt_size_meter;

  localparam int BPW      = 4;
  localparam int SIZE_MAX = 32767;
`ifdef PKT_METER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        rx_valid_i = 1'b0;
  logic        rx_sop_i = 1'b0;
  logic        rx_eop_i = 1'b0;
  logic [2:0]  rx_last_bytes_i = '0;
  logic [9:0]  rx_flow_num_i = '0;
  logic        wr_valid_o;
  logic        wr_ready_i = 1'b1;
  logic [9:0]  flow_num_o;
  logic [14:0] pkt_size_o;
  logic        sat_o;
  logic [15:0] drop_cnt_o;
  logic [15:0] err_cnt_o;

  int checks = 0;
  int errors = 0;
  int n_xfer = 0;

  pkt_size_meter dut (
    .clk_i           (clk_i),
    .rst_n_i         (rst_n_i),
    .rx_valid_i      (rx_valid_i),
    .rx_sop_i        (rx_sop_i),
    .rx_eop_i        (rx_eop_i),
    .rx_last_bytes_i (rx_last_bytes_i),
    .rx_flow_num_i   (rx_flow_num_i),
    .wr_valid_o      (wr_valid_o),
    .wr_ready_i      (wr_ready_i),
    .flow_num_o      (flow_num_o),
    .pkt_size_o      (pkt_size_o),
    .sat_o           (sat_o),
    .drop_cnt_o      (drop_cnt_o),
    .err_cnt_o       (err_cnt_o)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: packet-level view, words counted, size from arithmetic
  logic [25:0] exp_q[$];
  bit m_open;
  int m_words;
  int m_flow;
  bit m_valid;
  int m_rflow, m_rsize;
  bit m_rsat;
  int m_drop, m_err;

  always @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      m_open = 0; m_words = 0; m_flow = 0; m_valid = 0;
      m_rflow = 0; m_rsize = 0; m_rsat = 0; m_drop = 0; m_err = 0;
      exp_q.delete();
    end else begin
      bit commit;
      int cflow, csize, total, lbe;
      bit csat;
      commit = 0; cflow = 0; csize = 0; csat = 0;
      lbe = (rx_last_bytes_i == 0) ? BPW : int'(rx_last_bytes_i);
      if (rx_valid_i) begin
        if (rx_sop_i) begin
          if (m_open) m_err = (m_err < 65535) ? m_err + 1 : 65535;
          if (rx_eop_i) begin
            commit = 1; cflow = rx_flow_num_i; csize = lbe; m_open = 0;
          end else begin
            m_open = 1; m_words = 1; m_flow = rx_flow_num_i;
          end
        end else if (!m_open) begin
          m_err = (m_err < 65535) ? m_err + 1 : 65535;
        end else if (rx_eop_i) begin
          total = m_words * BPW + lbe;
          commit = 1; cflow = m_flow;
          csize = (total > SIZE_MAX) ? SIZE_MAX : total;
          csat = (total > SIZE_MAX);
          m_open = 0;
        end else begin
          m_words++;
        end
      end
      if (commit && (!m_valid || wr_ready_i)) begin
        m_valid = 1; m_rflow = cflow; m_rsize = csize; m_rsat = csat;
        exp_q.push_back({cflow[9:0], csize[14:0], csat});
      end else begin
        if (commit) m_drop = (m_drop < 65535) ? m_drop + 1 : 65535;
        if (m_valid && wr_ready_i) m_valid = 0;
      end
    end
  end

  // scoreboard / compare process on the falling edge
  always @(negedge clk_i) begin
    if (rst_n_i) begin
      check("valid", wr_valid_o, m_valid);
      if (m_valid) begin
        check("flow", flow_num_o, m_rflow);
        check("size", pkt_size_o, m_rsize);
        check("sat", sat_o, m_rsat);
      end
      check("drop_cnt", drop_cnt_o, STATS ? m_drop : 0);
      check("err_cnt", err_cnt_o, STATS ? m_err : 0);
      if (wr_valid_o && wr_ready_i) begin
        n_xfer++;
        if (exp_q.size() == 0) begin
          check("xfer_unexpected", 1, 0);
        end else begin
          logic [25:0] e;
          e = exp_q.pop_front();
          check("xfer_rec", {flow_num_o, pkt_size_o, sat_o}, e);
        end
      end
    end
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic send(input logic sop, input logic eop, input logic [2:0] lb, input logic [9:0] flow);
    rx_valid_i = 1'b1; rx_sop_i = sop; rx_eop_i = eop;
    rx_last_bytes_i = lb; rx_flow_num_i = flow;
    tick(1);
    rx_valid_i = 1'b0; rx_sop_i = 1'b0; rx_eop_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_n_i = 1'b0;
    tick(1);
    check("rst_valid", wr_valid_o, 0);
    check("rst_flow", flow_num_o, 0);
    check("rst_size", pkt_size_o, 0);
    check("rst_sat", sat_o, 0);
    check("rst_drop", drop_cnt_o, 0);
    check("rst_err", err_cnt_o, 0);
    rst_n_i = 1'b1;
    tick(1);
  endtask

  initial begin
    int x0;
    tick(2);
    do_reset();

    // single-word packet
    wr_ready_i = 1'b1;
    send(1, 1, 3'd3, 10'd5);
    check("single_valid", wr_valid_o, 1);
    check("single_flow", flow_num_o, 5);
    check("single_size", pkt_size_o, 3);
    check("single_sat", sat_o, 0);
    tick(2);

    // four-word packet, contiguous then with gaps
    send(1, 0, 3'd0, 10'd17); send(0, 0, 3'd0, 10'd0);
    send(0, 0, 3'd0, 10'd0);  send(0, 1, 3'd2, 10'd0);
    check("four_size", pkt_size_o, 14);
    check("four_flow", flow_num_o, 17);
    tick(2);
    send(1, 0, 3'd0, 10'd17); tick(2); send(0, 0, 3'd0, 10'd0); tick(1);
    send(0, 0, 3'd0, 10'd0);  tick(3); send(0, 1, 3'd2, 10'd0);
    check("gap_size", pkt_size_o, 14);
    check("gap_valid", wr_valid_o, 1);
    tick(2);

    // saturation: 8199 full words + 4 bytes = 32800
    send(1, 0, 3'd0, 10'd30);
    repeat (8198) send(0, 0, 3'd0, 10'd0);
    send(0, 1, 3'd4, 10'd0);
    check("sat_size", pkt_size_o, 32767);
    check("sat_bit", sat_o, 1);
    tick(2);

    // backpressure
    do_reset();
    wr_ready_i = 1'b0;
    send(1, 1, 3'd1, 10'd1); send(1, 1, 3'd1, 10'd2); send(1, 1, 3'd1, 10'd3);
    tick(2);
    check("bp_valid", wr_valid_o, 1);
    check("bp_flow", flow_num_o, 1);
    check("bp_drop", drop_cnt_o, STATS ? 2 : 0);
    x0 = n_xfer;
    wr_ready_i = 1'b1;
    tick(1);
    wr_ready_i = 1'b0;
    tick(3);
    check("bp_one_xfer", n_xfer - x0, 1);
    check("bp_empty", wr_valid_o, 0);
    wr_ready_i = 1'b1;

    // protocol errors: stray word, then abort by sop
    do_reset();
    send(0, 0, 3'd0, 10'd99);
    check("stray_ignored", wr_valid_o, 0);
    send(1, 0, 3'd0, 10'd7); send(0, 0, 3'd0, 10'd0);
    send(1, 0, 3'd0, 10'd9); send(0, 0, 3'd0, 10'd0);
    send(0, 1, 3'd1, 10'd0);
    check("abort_flow", flow_num_o, 9);
    check("abort_size", pkt_size_o, 9);
    check("err_total", err_cnt_o, STATS ? 2 : 0);
    tick(2);

    // reset in the middle of a packet
    send(1, 0, 3'd0, 10'd20); send(0, 0, 3'd0, 10'd0);
    do_reset();
    send(1, 0, 3'd0, 10'd21); send(0, 0, 3'd0, 10'd0);
    send(0, 0, 3'd0, 10'd0);  send(0, 1, 3'd3, 10'd0);
    check("post_rst_size", pkt_size_o, 15);
    check("post_rst_flow", flow_num_o, 21);
    tick(2);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      wr_ready_i = ($urandom_range(0, 99) < 70);
      if ($urandom_range(0, 99) < 75) begin
        rx_valid_i = 1'b1;
        rx_sop_i = ($urandom_range(0, 3) == 0);
        rx_eop_i = ($urandom_range(0, 2) == 0);
        rx_last_bytes_i = 3'($urandom_range(0, 4));
        rx_flow_num_i = 10'($urandom_range(0, 1023));
      end else begin
        rx_valid_i = 1'b0;
      end
      tick(1);
    end
    rx_valid_i = 1'b0;
    wr_ready_i = 1'b1;
    tick(4);
    check("queue_left", exp_q.size(), m_valid ? 1 : 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
